register_bank_reader: RTL

REGISTER_BANK_READER -- requirements
Module: register_bank_reader

---
 rtl/register_bank_reader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/register_bank_reader.sv
`default_nettype none
// ============================================================================
//  Module   : register_bank_reader
//  Purpose  : Reads cells out of a flattened ROWS x COLS register bank, one
//             cell per command (single read) or every cell in index order
//             (stream). Beats are presented with a valid/ready handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   rising-edge clock
//    clear        in   synchronous active-high reset, highest priority
//    bankData     in   ROWS*COLS*WIDTH flattened bank; cell k at
//                      [WIDTH*k +: WIDTH], k = row*COLS + col
//    readCmd      in   single-cell read request (honoured in IDLE only)
//    readAddr     in   {row[5:3], col[2:0]} of the requested cell
//    streamStart  in   stream-all-cells request (honoured in IDLE only)
//    outReady     in   consumer accepts the current beat
//    dataOut      out  cell value of the current beat
//    outValid     out  dataOut / outIndex carry a valid beat
//    outIndex     out  linear cell index k of the current beat
//    busy         out  high whenever the reader is not idle
//    addrError    out  one-cycle pulse when a single read is rejected
//    streamDone   out  one-cycle pulse after the final stream beat transfers
// ============================================================================
module register_bank_reader #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic [ROWS*COLS*WIDTH-1:0] bankData,
    input  logic                       readCmd,
    input  logic [5:0]                 readAddr,
    input  logic                       streamStart,
    input  logic                       outReady,
    output logic [WIDTH-1:0]           dataOut,
    output logic                       outValid,
    output logic [4:0]                 outIndex,
    output logic                       busy,
    output logic                       addrError,
    output logic                       streamDone
);

    // The 5-bit index space holds up to 32 cells.
    localparam int         c_NUM_CELLS = ROWS * COLS;
    localparam int         c_MAX_CELLS = 32;
    localparam logic [4:0] c_LAST_IDX  = 5'(c_NUM_CELLS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } stateType;

    stateType         r_state;
    logic [WIDTH-1:0] r_dataOut;
    logic             r_outValid;
    logic [4:0]       r_outIndex;
    logic             r_addrError;
    logic             r_streamDone;

    // ------------------------------------------------------------------------
    // Cell view of the bank. Padding the array to the full 5-bit index space
    // lets every cell lookup use a plain 5-bit index with no range concerns;
    // unused slots read as zero and are never selected by the FSM.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_cells [c_MAX_CELLS];

    for (genvar g = 0; g < c_MAX_CELLS; g++) begin : g_cells
        if (g < c_NUM_CELLS) begin : g_used
            assign w_cells[g] = bankData[g*WIDTH +: WIDTH];
        end else begin : g_pad
            assign w_cells[g] = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Single-read address decode
    // ------------------------------------------------------------------------
    logic [2:0] w_rowNum;
    logic [2:0] w_colNum;
    logic       w_addrOk;
    logic [4:0] w_singleIdx;
    logic [4:0] w_nextIdx;

    assign w_rowNum    = readAddr[5:3];
    assign w_colNum    = readAddr[2:0];
    assign w_addrOk    = (32'(w_rowNum) < 32'(ROWS)) && (32'(w_colNum) < 32'(COLS));
    assign w_singleIdx = 5'(32'(w_rowNum) * 32'(COLS) + 32'(w_colNum));
    assign w_nextIdx   = r_outIndex + 5'd1;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs. In SINGLE and STREAM outValid is
    // always 1, so a transfer in those states is simply outReady.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state      <= S_IDLE;
            r_dataOut    <= '0;
            r_outValid   <= 1'b0;
            r_outIndex   <= '0;
            r_addrError  <= 1'b0;
            r_streamDone <= 1'b0;
        end else begin
            // Both status outputs are single-cycle pulses by default.
            r_addrError  <= 1'b0;
            r_streamDone <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // readCmd takes precedence; a concurrent streamStart is
                    // dropped, even when the read itself is rejected.
                    if (readCmd) begin
                        if (w_addrOk) begin
                            r_state    <= S_SINGLE;
                            r_dataOut  <= w_cells[w_singleIdx];
                            r_outIndex <= w_singleIdx;
                            r_outValid <= 1'b1;
                        end else begin
                            r_addrError <= 1'b1;
                        end
                    end else if (streamStart) begin
                        r_state    <= S_STREAM;
                        r_dataOut  <= w_cells[0];
                        r_outIndex <= '0;
                        r_outValid <= 1'b1;
                    end
                end

                S_SINGLE: begin
                    if (outReady) begin
                        r_state    <= S_IDLE;
                        r_outValid <= 1'b0;
                    end
                end

                S_STREAM: begin
                    // Without a transfer nothing is reloaded, so the beat
                    // stays frozen even while bankData moves underneath.
                    if (outReady) begin
                        if (r_outIndex == c_LAST_IDX) begin
                            r_state      <= S_DONE;
                            r_outValid   <= 1'b0;
                            r_streamDone <= 1'b1;
                        end else begin
                            r_outIndex <= w_nextIdx;
                            r_dataOut  <= w_cells[w_nextIdx];
                        end
                    end
                end

                S_DONE: begin
                    // streamDone is high for this one cycle only.
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign dataOut    = r_dataOut;
    assign outValid   = r_outValid;
    assign outIndex   = r_outIndex;
    assign busy       = (r_state != S_IDLE);
    assign addrError  = r_addrError;
    assign streamDone = r_streamDone;

endmodule
`default_nettype wire
